// File: rtl/asw_pkg.sv
// Shared types and constants for the analog-switch scan controller.
package asw_pkg;

  localparam int NUM_DEV = 4;
  localparam int CH_W    = 3;
  localparam int ADDR_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DWELL     = 3'd4,
    ST_ADVANCE   = 3'd5
  } state_t;

  typedef struct packed {
    logic              found;
    logic [ADDR_W-1:0] idx;
  } dev_sel_t;

  // Lowest set bit of mask at index >= lo; found=0 when none remains.
  function automatic dev_sel_t find_dev(input logic [NUM_DEV-1:0] mask,
                                        input logic [ADDR_W:0]    lo);
    dev_sel_t sel;
    sel = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(lo))) begin
        sel.found = 1'b1;
        sel.idx   = ADDR_W'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/asw_scan_ctrl_if.sv
// Link between the scan controller and the switch writer / sample consumer.
// Handshake: the master pulses asw_start for one cycle with asw_addr and
// asw_channel valid in that cycle and held until the writer signals
// completion with a 0->1 transition on asw_done; a level already high is
// not a completion. sample_stb is a one-cycle pulse with cur_dev/cur_ch
// valid in the same cycle; there is no back-pressure on it.
interface asw_scan_ctrl_if;
  import asw_pkg::*;

  logic              asw_start;
  logic [ADDR_W-1:0] asw_addr;
  logic [CH_W-1:0]   asw_channel;
  logic              asw_done;
  logic              sample_stb;
  logic [ADDR_W-1:0] cur_dev;
  logic [CH_W-1:0]   cur_ch;

  modport master (
    output asw_start, asw_addr, asw_channel, sample_stb, cur_dev, cur_ch,
    input  asw_done
  );

  modport slave (
    input  asw_start, asw_addr, asw_channel, sample_stb, cur_dev, cur_ch,
    output asw_done
  );

endinterface

// File: rtl/asw_scan_ctrl.sv
// Scans enabled switch devices and their channel range: writes each
// (device, channel) to the switch, waits for completion, lets it settle for
// DWELL_CYC cycles and then strobes a sample. Channel is the inner loop.
module asw_scan_ctrl
  import asw_pkg::*;
#(
  parameter int DWELL_CYC   = 1000,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                scan_en,
  input  logic [NUM_DEV-1:0]  dev_mask,
  input  logic [CH_W-1:0]     first_ch,
  input  logic [CH_W-1:0]     last_ch,
  output logic                busy,
  output logic                timeout_err,
  output state_t              dbg_state,
  asw_scan_ctrl_if.master     bus
);

  localparam int CNT_MAX = (DWELL_CYC > TIMEOUT_CYC) ? DWELL_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_PRE    = CNT_W'((DWELL_CYC > 1) ? DWELL_CYC - 2 : 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_dev;
  logic [CH_W-1:0]     r_ch;
  logic [CH_W-1:0]     r_first;
  logic [CH_W-1:0]     r_last;
  logic [NUM_DEV-1:0]  r_mask;
  logic                r_asw_start;
  logic                r_sample_stb;
  logic                r_timeout_err;
  logic                r_done_q;

  logic                w_done_rise;
  dev_sel_t            w_lowest;
  dev_sel_t            w_next;

  assign w_done_rise = bus.asw_done & ~r_done_q;
  assign w_lowest    = find_dev(dev_mask, '0);
  assign w_next      = find_dev(r_mask, {1'b0, r_dev} + (ADDR_W + 1)'(1));

  // Scan sequencer: position, dwell/timeout counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_dev         <= '0;
      r_ch          <= '0;
      r_first       <= '0;
      r_last        <= '0;
      r_mask        <= '0;
      r_asw_start   <= 1'b0;
      r_sample_stb  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_done_q      <= 1'b0;
    end else begin
      r_done_q     <= bus.asw_done;
      r_asw_start  <= 1'b0;
      r_sample_stb <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (scan_en && (dev_mask != '0)) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          // Configuration is only ever captured here, so mid-scan edits
          // wait for the next wrap.
          r_first <= first_ch;
          r_last  <= last_ch;
          r_mask  <= dev_mask;
          if (w_lowest.found) begin
            r_dev       <= w_lowest.idx;
            r_ch        <= first_ch;
            r_asw_start <= 1'b1;
            r_state     <= ST_START;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_START: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (w_done_rise) begin
            r_cnt        <= '0;
            r_sample_stb <= (DWELL_CYC == 1);
            r_state      <= ST_DWELL;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_timeout_err <= 1'b1;
            r_cnt         <= '0;
            r_state       <= ST_ADVANCE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DWELL: begin
          // Strobe is raised one count early so it lands in the last dwell cycle.
          if (r_cnt == DWELL_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_ADVANCE;
          end else begin
            r_cnt        <= r_cnt + 1'b1;
            r_sample_stb <= (DWELL_CYC > 1) && (r_cnt == DWELL_PRE);
          end
        end
        ST_ADVANCE: begin
          if (!scan_en) begin
            r_state <= ST_IDLE;
          end else if (r_ch < r_last) begin
            // r_ch < r_last <= 7 means the increment can never wrap.
            r_ch        <= r_ch + 1'b1;
            r_asw_start <= 1'b1;
            r_state     <= ST_START;
          end else if (w_next.found) begin
            r_dev       <= w_next.idx;
            r_ch        <= r_first;
            r_asw_start <= 1'b1;
            r_state     <= ST_START;
          end else begin
            r_state <= ST_LOAD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.asw_start   = r_asw_start;
  assign bus.asw_addr    = r_dev;
  assign bus.asw_channel = r_ch;
  assign bus.sample_stb  = r_sample_stb;
  assign bus.cur_dev     = r_dev;
  assign bus.cur_ch      = r_ch;
  assign busy            = (r_state != ST_IDLE);
  assign timeout_err     = r_timeout_err;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_asw_scan_ctrl.sv
// Directed bench for asw_scan_ctrl with DWELL_CYC=10, TIMEOUT_CYC=50.
module tb_asw_scan_ctrl;
  import asw_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scan_en = 1'b0;
  logic [3:0]  dev_mask = 4'b0000;
  logic [2:0]  first_ch = 3'd0;
  logic [2:0]  last_ch = 3'd0;
  logic        busy;
  logic        timeout_err;
  state_t      dbg_state;

  asw_scan_ctrl_if bus_if ();

  asw_scan_ctrl #(.DWELL_CYC(10), .TIMEOUT_CYC(50)) dut (
    .clk         (clk),
    .reset       (reset),
    .scan_en     (scan_en),
    .dev_mask    (dev_mask),
    .first_ch    (first_ch),
    .last_ch     (last_ch),
    .busy        (busy),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state),
    .bus         (bus_if)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [4:0] exp_q[$];
  logic [4:0] start_q[$];
  logic [4:0] stb_q[$];
  int         start_cyc_q[$];
  int         stb_cyc_q[$];
  int         done_cyc_q[$];
  bit         resp_en = 1'b0;

  // Monitor: log every start and sample strobe with its cycle
  always @(negedge clk) begin
    if (bus_if.asw_start) begin
      start_q.push_back({bus_if.asw_addr, bus_if.asw_channel});
      start_cyc_q.push_back(cyc);
    end
    if (bus_if.sample_stb) begin
      stb_q.push_back({bus_if.cur_dev, bus_if.cur_ch});
      stb_cyc_q.push_back(cyc);
    end
  end

  // Writer model: done rises 2 cycles after start, held for 2 cycles
  initial begin
    bus_if.asw_done = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && bus_if.asw_start) begin
        repeat (2) @(negedge clk);
        bus_if.asw_done = 1'b1;
        done_cyc_q.push_back(cyc);
        repeat (2) @(negedge clk);
        bus_if.asw_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic clear_logs();
    exp_q.delete();
    start_q.delete();
    stb_q.delete();
    start_cyc_q.delete();
    stb_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int t;
    t = 0;
    while ((start_q.size() < n) && (t < budget)) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (start_q.size() < n) begin
      errors++;
      $display("FAIL %s: start count got %0d required %0d", name, start_q.size(), n);
    end
  endtask

  task automatic compare_starts(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= start_q.size()) begin
        errors++;
        $display("FAIL %s[%0d]: start missing, required %0h", name, i, exp_q[i]);
      end else if (start_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s[%0d]: {addr,ch} got %0h required %0h", name, i, start_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic stop_scan(input string name);
    int t;
    scan_en = 1'b0;
    t = 0;
    while (busy && (t < 300)) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy got %b required 0", name, busy);
    end
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    scan_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks += 9;
    if (bus_if.asw_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b required 0", bus_if.asw_start); end
    if (bus_if.asw_addr !== 2'd0) begin errors++; $display("FAIL rst_addr: got %0d required 0", bus_if.asw_addr); end
    if (bus_if.asw_channel !== 3'd0) begin errors++; $display("FAIL rst_channel: got %0d required 0", bus_if.asw_channel); end
    if (bus_if.sample_stb !== 1'b0) begin errors++; $display("FAIL rst_stb: got %b required 0", bus_if.sample_stb); end
    if (bus_if.cur_dev !== 2'd0) begin errors++; $display("FAIL rst_cur_dev: got %0d required 0", bus_if.cur_dev); end
    if (bus_if.cur_ch !== 3'd0) begin errors++; $display("FAIL rst_cur_ch: got %0d required 0", bus_if.cur_ch); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b required 0", timeout_err); end
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d required %0d", dbg_state, ST_IDLE); end
    reset = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_idle_mask0();
    clear_logs();
    dev_mask = 4'b0000;
    scan_en = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL mask0_busy: got %b required 0", busy); end
    if (start_q.size() != 0) begin errors++; $display("FAIL mask0_starts: got %0d required 0", start_q.size()); end
    scan_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_dev();
    clear_logs();
    resp_en = 1'b1;
    dev_mask = 4'b0001; first_ch = 3'd0; last_ch = 3'd2;
    scan_en = 1'b1;
    wait_starts(4, 200, "single_wait");
    exp_q = '{{2'd0, 3'd0}, {2'd0, 3'd1}, {2'd0, 3'd2}, {2'd0, 3'd0}};
    compare_starts("single_start");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= stb_q.size() || i >= done_cyc_q.size()) begin
        errors++;
        $display("FAIL single_stb[%0d]: strobe or done missing", i);
      end else if (stb_q[i] !== exp_q[i] || (stb_cyc_q[i] - done_cyc_q[i]) != 10) begin
        errors++;
        $display("FAIL single_stb[%0d]: pos %0h delay %0d required pos %0h delay 10",
                 i, stb_q[i], stb_cyc_q[i] - done_cyc_q[i], exp_q[i]);
      end
    end
    checks++;
    if (start_cyc_q.size() >= 2 && (start_cyc_q[1] - start_cyc_q[0]) != 14) begin
      errors++;
      $display("FAIL single_spacing: got %0d required 14", start_cyc_q[1] - start_cyc_q[0]);
    end
    stop_scan("single_stop");
  endtask

  task automatic test_two_dev();
    clear_logs();
    resp_en = 1'b1;
    dev_mask = 4'b1010; first_ch = 3'd6; last_ch = 3'd7;
    scan_en = 1'b1;
    wait_starts(1, 20, "two_wait0");
    // Edited mid-scan; must only show up after the wrap.
    dev_mask = 4'b0100; first_ch = 3'd2; last_ch = 3'd2;
    wait_starts(6, 400, "two_wait");
    exp_q = '{{2'd1, 3'd6}, {2'd1, 3'd7}, {2'd3, 3'd6}, {2'd3, 3'd7}, {2'd2, 3'd2}, {2'd2, 3'd2}};
    compare_starts("two_start");
    if (start_cyc_q.size() >= 5) begin
      checks += 2;
      if ((start_cyc_q[2] - start_cyc_q[1]) != 14) begin
        errors++;
        $display("FAIL two_dev_switch_gap: got %0d required 14", start_cyc_q[2] - start_cyc_q[1]);
      end
      if ((start_cyc_q[4] - start_cyc_q[3]) != 15) begin
        errors++;
        $display("FAIL two_wrap_gap: got %0d required 15", start_cyc_q[4] - start_cyc_q[3]);
      end
    end
    stop_scan("two_stop");
  endtask

  task automatic test_range_inverted();
    clear_logs();
    resp_en = 1'b1;
    dev_mask = 4'b0001; first_ch = 3'd5; last_ch = 3'd2;
    scan_en = 1'b1;
    wait_starts(3, 200, "inv_wait");
    exp_q = '{{2'd0, 3'd5}, {2'd0, 3'd5}, {2'd0, 3'd5}};
    compare_starts("inv_start");
    checks++;
    if (stb_q.size() == 0 || stb_q[0] !== 5'b00101) begin
      errors++;
      $display("FAIL inv_stb: got %0h required 5", (stb_q.size() > 0) ? stb_q[0] : 5'h1f);
    end
    stop_scan("inv_stop");
  endtask

  task automatic test_timeout();
    int k;
    clear_logs();
    resp_en = 1'b0;
    dev_mask = 4'b0001; first_ch = 3'd0; last_ch = 3'd1;
    scan_en = 1'b1;
    wait_starts(1, 20, "to_wait");
    k = (start_cyc_q.size() > 0) ? start_cyc_q[0] : cyc;
    wait_cyc(k + 50);
    checks += 2;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: got %b required 0", timeout_err); end
    if (dbg_state !== ST_WAIT_DONE) begin errors++; $display("FAIL to_state_wait: got %0d required %0d", dbg_state, ST_WAIT_DONE); end
    wait_cyc(k + 51);
    checks += 2;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set: got %b required 1", timeout_err); end
    if (dbg_state !== ST_ADVANCE) begin errors++; $display("FAIL to_state_adv: got %0d required %0d", dbg_state, ST_ADVANCE); end
    wait_cyc(k + 52);
    checks += 2;
    if (bus_if.asw_start !== 1'b1) begin errors++; $display("FAIL to_next_start: got %b required 1", bus_if.asw_start); end
    if ({bus_if.asw_addr, bus_if.asw_channel} !== 5'b00001) begin
      errors++;
      $display("FAIL to_next_pos: got %0h required 1", {bus_if.asw_addr, bus_if.asw_channel});
    end
    checks++;
    if (stb_q.size() != 0) begin errors++; $display("FAIL to_no_stb: got %0d strobes required 0", stb_q.size()); end
    stop_scan("to_stop");
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b required 1", timeout_err); end
  endtask

  task automatic test_reset_in_wait();
    clear_logs();
    resp_en = 1'b0;
    dev_mask = 4'b0001; first_ch = 3'd3; last_ch = 3'd3;
    scan_en = 1'b1;
    wait_starts(1, 20, "rw_wait");
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (dbg_state !== ST_WAIT_DONE) begin errors++; $display("FAIL rw_pre_state: got %0d required %0d", dbg_state, ST_WAIT_DONE); end
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks += 6;
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rw_state: got %0d required %0d", dbg_state, ST_IDLE); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rw_busy: got %b required 0", busy); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL rw_timeout: got %b required 0", timeout_err); end
    if (bus_if.asw_channel !== 3'd0) begin errors++; $display("FAIL rw_channel: got %0d required 0", bus_if.asw_channel); end
    if (bus_if.asw_start !== 1'b0) begin errors++; $display("FAIL rw_start: got %b required 0", bus_if.asw_start); end
    if (bus_if.sample_stb !== 1'b0) begin errors++; $display("FAIL rw_stb: got %b required 0", bus_if.sample_stb); end
    repeat (3) @(negedge clk);
    scan_en = 1'b0;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (start_q.size() != 1) begin errors++; $display("FAIL rw_no_restart: got %0d starts required 1", start_q.size()); end
  endtask

  task automatic test_stop_in_dwell();
    int t;
    int s;
    clear_logs();
    resp_en = 1'b1;
    dev_mask = 4'b0001; first_ch = 3'd0; last_ch = 3'd2;
    scan_en = 1'b1;
    wait_starts(2, 100, "sd_wait");
    t = 0;
    while (dbg_state !== ST_DWELL && t < 20) begin @(negedge clk); #1; t++; end
    scan_en = 1'b0;
    t = 0;
    while (stb_q.size() < 2 && t < 30) begin @(negedge clk); #1; t++; end
    checks++;
    if (stb_q.size() < 2 || stb_q[1] !== 5'b00001) begin
      errors++;
      $display("FAIL sd_stb: strobes %0d, second pos got %0h required 1",
               stb_q.size(), (stb_q.size() > 1) ? stb_q[1] : 5'h1f);
    end
    s = (stb_cyc_q.size() > 1) ? stb_cyc_q[1] : cyc;
    wait_cyc(s + 1);
    checks++;
    if (dbg_state !== ST_ADVANCE) begin errors++; $display("FAIL sd_adv: got %0d required %0d", dbg_state, ST_ADVANCE); end
    wait_cyc(s + 2);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL sd_busy: got %b required 0", busy); end
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (start_q.size() != 2) begin errors++; $display("FAIL sd_no_start: got %0d starts required 2", start_q.size()); end
  endtask

  initial begin
    test_reset();
    test_idle_mask0();
    test_single_dev();
    test_two_dev();
    test_range_inverted();
    test_timeout();
    test_reset_in_wait();
    test_stop_in_dwell();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/asw_scan_ctrl.md
ASW_SCAN_CTRL -- requirements
Module: asw_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_CYC, default 1000, meaning settle cycles after each switch write before a sample strobe (min 1).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 20000, meaning max cycles waiting for write completion (min 1).
REQ-003 clk  in  1  system clock, 100 MHz; single clock domain.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 scan_en  in  1  level; high runs the scan, low stops it after the current write.
REQ-006 dev_mask  in  4  enable per switch device address 0..3.
REQ-007 first_ch  in  3  first channel of the scan range.
REQ-008 last_ch  in  3  last channel of the scan range.
REQ-009 asw_start  out  1  one-cycle start pulse to the switch writer.
REQ-010 asw_addr  out  2  device address to the writer; stable from asw_start until done.
REQ-011 asw_channel  out  3  channel to the writer; stable from asw_start until done.
REQ-012 asw_done  in  1  writer stop flag; its rising edge marks write complete.
REQ-013 sample_stb  out  1  one-cycle pulse when the selected channel has settled.
REQ-014 cur_dev  out  2 and cur_ch  out  3  device and channel valid at sample_stb.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 timeout_err  out  1  sticky; set on write timeout; cleared only by reset.

Function
REQ-017 FSM states: IDLE, LOAD, START, WAIT_DONE, DWELL, ADVANCE.
REQ-018 IDLE -> LOAD when scan_en=1 and dev_mask!=0; otherwise stay in IDLE.
REQ-019 LOAD: on scan start, register first_ch/last_ch/dev_mask; pick the lowest set dev_mask bit and first_ch; go to START.
REQ-020 START: drive asw_start=1 for exactly one cycle with asw_addr/asw_channel valid that same cycle; go to WAIT_DONE.
REQ-021 WAIT_DONE: on detected rising edge of asw_done go to DWELL; the dwell counter starts the next cycle.
REQ-022 WAIT_DONE: if TIMEOUT_CYC cycles pass without the edge, set timeout_err, skip the sample_stb and go to ADVANCE.
REQ-023 DWELL: count DWELL_CYC cycles; on the last count pulse sample_stb with cur_dev/cur_ch; go to ADVANCE.
REQ-024 ADVANCE: if scan_en=0 go to IDLE.
REQ-025 ADVANCE with scan_en=1, channel ordering: channel is the inner loop; increment channel until last_ch.
REQ-026 ADVANCE with scan_en=1, device ordering: after last_ch, move to the next higher set bit of the latched dev_mask and reset to first_ch.
REQ-027 ADVANCE with scan_en=1, wrap: after the highest set device bit, go to LOAD, which re-latches the configuration.
REQ-028 If first_ch > last_ch, only first_ch is scanned on each device.
REQ-029 Channel increment SHALL NOT wrap 7->0 inside a device; 7 always terminates the device.
REQ-030 Configuration inputs are sampled only in LOAD; changes mid-scan take effect at the next wrap.
REQ-031 scan_en falling during WAIT_DONE or DWELL: the current write completes and, in DWELL, its sample_stb still fires; then ADVANCE -> IDLE.
REQ-032 asw_done already high on entry to WAIT_DONE is not an edge; the bench waits for a 0->1 transition.
REQ-033 Start-to-start spacing is at least 3 cycles (START, WAIT_DONE, ADVANCE).

Reset
REQ-034 In reset: state IDLE; asw_start=0, asw_addr=0, asw_channel=0, sample_stb=0, cur_dev=0, cur_ch=0, busy=0, timeout_err=0; all counters 0.
REQ-035 Reset asserted mid-scan SHALL abort the scan in the same cycle, with no further asw_start.

Structure
REQ-036 Shared package asw_pkg holds the FSM state enum, NUM_DEV=4, CH_W=3, ADDR_W=2.
REQ-037 Single flat module; counters are inline; no sub-module.

Verification
REQ-038 dev_mask=0001, first=0, last=2, DWELL=10: starts at (0,0),(0,1),(0,2),(0,0)...; each sample_stb 10 cycles after its done edge.
REQ-039 dev_mask=1010, first=6, last=7: start order (1,6),(1,7),(3,6),(3,7), then wrap.
REQ-040 asw_done never toggles, TIMEOUT=50: timeout_err=1 at cycle 50 of WAIT_DONE, no sample_stb, next channel started.
REQ-041 scan_en dropped during DWELL of (0,1): sample_stb for (0,1) fires, busy=0 on the cycle after ADVANCE, no new asw_start.
REQ-042 first=5, last=2, dev_mask=0001: only channel 5 is written, repeatedly.
REQ-043 reset pulsed in WAIT_DONE: all outputs at reset values the next cycle; timeout_err cleared.
